unidade_controle_contagem: RTL and testbench

// - Control unit for the 74163 counter + 7485 comparator datapath.
// - Drives the counter's active-low clear, active-low load and ENP pins.
// - Drives the comparator's B operand; reads back comparator A=B and counter RCO.
// - Runs one count from VALOR_INICIAL up to LIMITE; reports PRONTO or ERRO.

---
 rtl/unidade_controle_contagem.sv | 138 +++++++++++++
 tb/tb_unidade_controle_contagem.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_contagem.sv
// Control unit sequencing a 74163 counter against a 7485 comparator for one VALOR_INICIAL..LIMITE run.
// Optional build macro AUTO_REPETIR_EN: restart the same run automatically after every match.
module unidade_controle_contagem #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             INICIAR,
  input  logic             PAUSAR,
  input  logic [WIDTH-1:0] VALOR_INICIAL,
  input  logic [WIDTH-1:0] LIMITE,
  input  logic             IGUAL,
  input  logic             RCO,
  output logic             ZERA_N,
  output logic             CARREGA_N,
  output logic             CONTA,
  output logic [WIDTH-1:0] DADO_CARGA,
  output logic [WIDTH-1:0] COMPARA_B,
  output logic [WIDTH-1:0] PULSOS,
  output logic             PRONTO,
  output logic             ERRO,
  output logic [2:0]       ESTADO
);

  typedef enum logic [2:0] {
    S_INICIAL  = 3'd0,
    S_PREPARA  = 3'd1,
    S_CARREGA  = 3'd2,
    S_CONTANDO = 3'd3,
    S_PAUSA    = 3'd4,
    S_FIM      = 3'd5,
    S_ERRO     = 3'd6
  } estado_t;

  estado_t          state_q, state_d;
  logic [WIDTH-1:0] valor_q, valor_d;
  logic [WIDTH-1:0] limite_q, limite_d;
  logic [WIDTH-1:0] pulsos_q, pulsos_d;
  logic             conta_s;
  logic             start_s;

  // State and captured-operand registers
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q  <= S_INICIAL;
      valor_q  <= {WIDTH{1'b0}};
      limite_q <= {WIDTH{1'b0}};
      pulsos_q <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      valor_q  <= valor_d;
      limite_q <= limite_d;
      pulsos_q <= pulsos_d;
    end
  end

  // Next-state, capture and pulse-count logic
  always_comb begin
    state_d  = state_q;
    valor_d  = valor_q;
    limite_d = limite_q;
    pulsos_d = pulsos_q;
    conta_s  = 1'b0;
    start_s  = 1'b0;
    case (state_q)
      S_INICIAL, S_ERRO: begin
        start_s = INICIAR;
      end
      S_PREPARA: begin
        state_d = S_CARREGA;
      end
      S_CARREGA: begin
        state_d = S_CONTANDO;
      end
      S_CONTANDO: begin
        conta_s = !IGUAL && !PAUSAR;
        // Match beats wrap: at LIMITE = all-ones both flags rise together
        if (IGUAL) begin
          state_d = S_FIM;
        end else if (RCO) begin
          state_d = S_ERRO;
        end else if (PAUSAR) begin
          state_d = S_PAUSA;
        end else begin
          state_d = S_CONTANDO;
        end
        if (conta_s) begin
          pulsos_d = pulsos_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          pulsos_d = pulsos_q;
        end
      end
      S_PAUSA: begin
        if (!PAUSAR) begin
          state_d = S_CONTANDO;
        end else begin
          state_d = S_PAUSA;
        end
      end
      S_FIM: begin
`ifdef AUTO_REPETIR_EN
        state_d  = S_CARREGA;
        pulsos_d = {WIDTH{1'b0}};
`else
        start_s = INICIAR;
`endif
      end
      default: begin
        state_d = S_INICIAL;
      end
    endcase

    // An inverted range is rejected before the counter is ever loaded
    if (start_s) begin
      valor_d  = VALOR_INICIAL;
      limite_d = LIMITE;
      pulsos_d = {WIDTH{1'b0}};
      if (VALOR_INICIAL > LIMITE) begin
        state_d = S_ERRO;
      end else begin
        state_d = S_PREPARA;
      end
    end else begin
      valor_d = valor_d;
    end
  end

  assign ZERA_N     = !((state_q == S_INICIAL) || (state_q == S_PREPARA) || (state_q == S_ERRO));
  assign CARREGA_N  = (state_q != S_CARREGA);
  assign CONTA      = conta_s;
  assign DADO_CARGA = valor_q;
  assign COMPARA_B  = limite_q;
  assign PULSOS     = pulsos_q;
  assign PRONTO     = (state_q == S_FIM);
  assign ERRO       = (state_q == S_ERRO);
  assign ESTADO     = state_q;

endmodule

// File: tb/tb_unidade_controle_contagem.sv
// Bench for unidade_controle_contagem with a behavioural 74163/7485 datapath around it.
module tb_unidade_controle_contagem;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       INICIAR = 1'b0;
  logic       PAUSAR = 1'b0;
  logic [3:0] VALOR_INICIAL = 4'd0;
  logic [3:0] LIMITE = 4'd0;
  logic       IGUAL, RCO;
  logic       ZERA_N, CARREGA_N, CONTA, PRONTO, ERRO;
  logic [3:0] DADO_CARGA, COMPARA_B, PULSOS;
  logic [2:0] ESTADO;
  logic [3:0] q = 4'd0;

  int n_assert = 0;
  int n_fail   = 0;

  unidade_controle_contagem #(.WIDTH(4)) dut (
    .CLK(CLK), .CLR(CLR), .INICIAR(INICIAR), .PAUSAR(PAUSAR),
    .VALOR_INICIAL(VALOR_INICIAL), .LIMITE(LIMITE), .IGUAL(IGUAL), .RCO(RCO),
    .ZERA_N(ZERA_N), .CARREGA_N(CARREGA_N), .CONTA(CONTA),
    .DADO_CARGA(DADO_CARGA), .COMPARA_B(COMPARA_B), .PULSOS(PULSOS),
    .PRONTO(PRONTO), .ERRO(ERRO), .ESTADO(ESTADO)
  );

  always #5 CLK = ~CLK;

  // 74163 with ENT tied high, synchronous clear over load over count
  always @(posedge CLK) begin
    if (!ZERA_N) q <= 4'd0;
    else if (!CARREGA_N) q <= DADO_CARGA;
    else if (CONTA) q <= q + 4'd1;
  end
  assign IGUAL = (q == COMPARA_B);
  assign RCO   = (q == 4'hF);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_zera_n", 32'(ZERA_N), 32'd0);
    check("rst_carrega_n", 32'(CARREGA_N), 32'd1);
    check("rst_conta", 32'(CONTA), 32'd0);
    check("rst_dado_carga", 32'(DADO_CARGA), 32'd0);
    check("rst_compara_b", 32'(COMPARA_B), 32'd0);
    check("rst_pulsos", 32'(PULSOS), 32'd0);
    check("rst_pronto", 32'(PRONTO), 32'd0);
    check("rst_erro", 32'(ERRO), 32'd0);
    check("rst_estado", 32'(ESTADO), 32'd0);
  endtask

  // One run from v to l; a hold of pl cycles starting at counting cycle ps (ps<0: none)
  task automatic run(input int v, input int l, input int ps, input int pl);
    int e;
    int extra;
    int seen;
    extra = (ps >= 0) ? pl + 1 : 0;   // the hold plus the cycle spent leaving it
    VALOR_INICIAL = 4'(v);
    LIMITE = 4'(l);
    INICIAR = 1'b1;
    PAUSAR = 1'b0;
    tick();
    INICIAR = 1'b0;
    VALOR_INICIAL = 4'($urandom);
    LIMITE = 4'($urandom);
    if (v > l) begin
      check("bad_erro", 32'(ERRO), 32'd1);
      check("bad_estado", 32'(ESTADO), 32'd6);
      check("bad_pulsos", 32'(PULSOS), 32'd0);
      check("bad_pronto", 32'(PRONTO), 32'd0);
      for (int k = 0; k < 3; k++) begin
        check("bad_zera_n", 32'(ZERA_N), 32'd0);
        check("bad_carrega_n", 32'(CARREGA_N), 32'd1);
        tick();
      end
      check("bad_counter_q", 32'(q), 32'd0);
      check("bad_erro_held", 32'(ERRO), 32'd1);
    end else begin
      e = 3 + (l - v) + extra;
      seen = 0;
      check("start_estado", 32'(ESTADO), 32'd1);
      for (int k = 0; k < e; k++) begin
        PAUSAR = (ps >= 0) && (k - 2 >= ps) && (k - 2 < ps + pl);
        INICIAR = 1'($urandom_range(0, 1));
        VALOR_INICIAL = 4'($urandom);
        LIMITE = 4'($urandom);
        #1;
        if (CONTA === 1'b1) seen++;
        check("pronto_early", 32'(PRONTO), 32'd0);
        check("erro_during_run", 32'(ERRO), 32'd0);
        tick();
      end
      INICIAR = 1'b0;
      PAUSAR = 1'b0;
      #1;
      check("fim_pronto", 32'(PRONTO), 32'd1);
      check("fim_estado", 32'(ESTADO), 32'd5);
      check("fim_erro", 32'(ERRO), 32'd0);
      check("fim_pulsos", 32'(PULSOS), 32'(l - v));
      check("conta_cycles", 32'(seen), 32'(l - v));
      check("fim_dado_carga", 32'(DADO_CARGA), 32'(v));
      check("fim_compara_b", 32'(COMPARA_B), 32'(l));
      check("fim_counter_q", 32'(q), 32'(l));
`ifndef AUTO_REPETIR_EN
      tick();
      tick();
      check("fim_pronto_held", 32'(PRONTO), 32'd1);
      check("fim_pulsos_held", 32'(PULSOS), 32'(l - v));
`endif
    end
  endtask

  initial begin
    int v;
    int l;
    int ps;
    int pl;
    CLR = 1'b1;
    tick();
    tick();
    CLR = 1'b0;
    #1;
    check_reset_outputs();

`ifdef AUTO_REPETIR_EN
    VALOR_INICIAL = 4'd2;
    LIMITE = 4'd4;
    INICIAR = 1'b1;
    tick();
    INICIAR = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("auto_pronto", 32'(PRONTO), (k >= 5 && (k - 5) % 5 == 0) ? 32'd1 : 32'd0);
      if (PRONTO === 1'b1) check("auto_pulsos", 32'(PULSOS), 32'd2);
    end
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    #1;
    check("auto_stop_estado", 32'(ESTADO), 32'd0);
`else
    run(3, 7, -1, 0);
    run(5, 5, -1, 0);
    run(9, 2, -1, 0);
    run(0, 15, 6, 3);
    run(15, 15, -1, 0);
    run(0, 0, -1, 0);
    for (int r = 0; r < 20; r++) begin
      v = $urandom_range(0, 15);
      if ($urandom_range(0, 4) == 0 && v > 0) l = $urandom_range(0, v - 1);
      else l = $urandom_range(v, 15);
      ps = -1;
      pl = 0;
      if (l > v && $urandom_range(0, 1) == 1) begin
        ps = $urandom_range(0, l - v - 1);
        pl = $urandom_range(1, 4);
      end
      run(v, l, ps, pl);
    end

    // Synchronous reset in the middle of a count
    VALOR_INICIAL = 4'd0;
    LIMITE = 4'd15;
    INICIAR = 1'b1;
    tick();
    INICIAR = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("abort_counting", 32'(ESTADO), 32'd3);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    #1;
    check("abort_estado", 32'(ESTADO), 32'd0);
    check("abort_conta", 32'(CONTA), 32'd0);
    check("abort_pulsos", 32'(PULSOS), 32'd0);
    check("abort_zera_n", 32'(ZERA_N), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
